// File: rtl/piso_serializer_if.sv
// Parallel word handshake into the serializer.
// Source drives Par_IN/In_Valid; serializer answers In_Ready.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Par_IN;
  logic             In_Valid;
  logic             In_Ready;

  modport master (
    output Par_IN,
    output In_Valid,
    input  In_Ready
  );

  modport slave (
    input  Par_IN,
    input  In_Valid,
    output In_Ready
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first.
// Back-to-back frames reload on the last bit; Hold freezes the link.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  piso_serializer_if.slave up,
  input  logic             Hold,
  output logic             Serial_OUT,
  output logic             Out_Valid,
  output logic             Busy,
  output logic             Frame_Done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             done_q;
  logic             done_d;
  logic             last;
  logic             accept;

  assign last        = (state_q == SHIFT) && (cnt_q == LAST);
  assign Out_Valid   = (state_q == SHIFT) && !Hold;
  assign up.In_Ready = (state_q == IDLE) || (last && !Hold);
  assign accept      = up.In_Valid && up.In_Ready;
  assign Serial_OUT  = (state_q == SHIFT) ? sr_q[0] : 1'b0;
  assign Busy        = (state_q == SHIFT);
  assign Frame_Done  = done_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = up.Par_IN;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (Out_Valid) begin
          if (last) begin
            done_d = 1'b1;
            cnt_d  = '0;
            // reload without a gap if the next word is waiting
            if (accept) begin
              sr_d = up.Par_IN;
            end else begin
              sr_d    = sr_q >> 1;
              state_d = IDLE;
            end
          end else begin
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with bit scoreboards
// and a reference SIPO receiver model.
module tb_piso_serializer;
  logic clk;
  logic rst_n;
  logic hold4;
  logic hold8;
  logic so4, ov4, busy4, fdn4;
  logic so8, ov8, busy8, fdn8;

  piso_serializer_if #(.WIDTH(4)) if4 ();
  piso_serializer_if #(.WIDTH(8)) if8 ();

  piso_serializer #(.WIDTH(4)) u4 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .up        (if4),
    .Hold      (hold4),
    .Serial_OUT(so4),
    .Out_Valid (ov4),
    .Busy      (busy4),
    .Frame_Done(fdn4)
  );

  piso_serializer #(.WIDTH(8)) u8 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .up        (if8),
    .Hold      (hold8),
    .Serial_OUT(so8),
    .Out_Valid (ov8),
    .Busy      (busy8),
    .Frame_Done(fdn8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vec = 0;
  int   errs = 0;
  logic q4[$];
  logic q8[$];
  int   nv4, fd4, run4, max4;
  int   nv8, fd8;
  logic [3:0] rx4;
  logic [7:0] rx8;
  logic ov_s, so_s, rdy_s, busy_s, fdn_s;
  logic acc4, acc8;
  int   k;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nv4 = 0; fd4 = 0; run4 = 0; max4 = 0;
    nv8 = 0; fd8 = 0;
  endtask

  // sample just after inputs settle, then advance one clock
  task automatic tick();
    logic b;
    #1;
    ov_s = ov4; so_s = so4; rdy_s = if4.In_Ready;
    busy_s = busy4; fdn_s = fdn4;
    acc4 = 1'b0; acc8 = 1'b0;
    if (fdn4 === 1'b1) fd4++;
    if (fdn8 === 1'b1) fd8++;
    if (ov4 === 1'b1) begin
      nv4++; run4++;
      if (run4 > max4) max4 = run4;
      rx4 = {so4, rx4[3:1]};
      chk("q4_has_bit", q4.size() != 0, 1);
      if (q4.size() != 0) begin
        b = q4.pop_front();
        chk("bit4", so4, b);
      end
    end else run4 = 0;
    if (ov8 === 1'b1) begin
      nv8++;
      rx8 = {so8, rx8[7:1]};
      chk("q8_has_bit", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        b = q8.pop_front();
        chk("bit8", so8, b);
      end
    end
    if (if4.In_Valid === 1'b1 && if4.In_Ready === 1'b1) begin
      acc4 = 1'b1;
      for (int i = 0; i < 4; i++) q4.push_back(if4.Par_IN[i]);
    end
    if (if8.In_Valid === 1'b1 && if8.In_Ready === 1'b1) begin
      acc8 = 1'b1;
      for (int i = 0; i < 8; i++) q8.push_back(if8.Par_IN[i]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; hold4 = 1'b0; hold8 = 1'b0;
    if4.Par_IN = '0; if4.In_Valid = 1'b0;
    if8.Par_IN = '0; if8.In_Valid = 1'b0;
    rx4 = '0; rx8 = '0; k = -1;
    clr();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    tick();
    chk("rst_busy", busy_s, 0);
    chk("rst_done", fdn_s, 0);
    chk("rst_sout", so_s, 0);
    chk("rst_ov", ov_s, 0);
    chk("rst_ready", rdy_s, 1);

    // single frame
    clr();
    if4.Par_IN = 4'b1011; if4.In_Valid = 1'b1;
    tick();
    chk("t1_acc", acc4, 1);
    if4.In_Valid = 1'b0;
    idle(8);
    chk("t1_nv", nv4, 4);
    chk("t1_fd", fd4, 1);
    chk("t1_rx", rx4, 4'b1011);
    chk("t1_busy", busy4, 0);
    chk("t1_q", q4.size(), 0);

    // back-to-back
    clr(); k = -1;
    if4.Par_IN = 4'hA; if4.In_Valid = 1'b1;
    tick();
    if4.Par_IN = 4'h5;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc4) begin k = i; break; end
    end
    if4.In_Valid = 1'b0;
    chk("t2_acc_at", k, 3);
    idle(8);
    chk("t2_nv", nv4, 8);
    chk("t2_run", max4, 8);
    chk("t2_fd", fd4, 2);
    chk("t2_rx", rx4, 4'h5);
    chk("t2_q", q4.size(), 0);

    // hold mid-frame
    clr();
    if4.Par_IN = 4'b0110; if4.In_Valid = 1'b1;
    tick();
    if4.In_Valid = 1'b0;
    idle(2);
    hold4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_ov", ov_s, 0);
      chk("t3_hold_so", so_s, 1);
      chk("t3_hold_rdy", rdy_s, 0);
    end
    hold4 = 1'b0;
    idle(8);
    chk("t3_nv", nv4, 4);
    chk("t3_fd", fd4, 1);
    chk("t3_rx", rx4, 4'b0110);

    // busy rejection
    clr(); k = -1;
    if4.Par_IN = 4'h3; if4.In_Valid = 1'b1;
    tick();
    if4.In_Valid = 1'b0;
    tick();
    if4.Par_IN = 4'hF; if4.In_Valid = 1'b1;
    tick();
    chk("t4_rdy", rdy_s, 0);
    chk("t4_noacc", acc4, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc4) begin k = i; break; end
    end
    if4.In_Valid = 1'b0;
    chk("t4_acc_at", k, 1);
    idle(8);
    chk("t4_nv", nv4, 8);
    chk("t4_fd", fd4, 2);
    chk("t4_rx", rx4, 4'hF);

    // reset mid-frame
    clr();
    if4.Par_IN = 4'h9; if4.In_Valid = 1'b1;
    tick();
    if4.In_Valid = 1'b0;
    idle(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q4.delete();
    fd4 = 0;
    tick();
    chk("t5_busy", busy_s, 0);
    chk("t5_ov", ov_s, 0);
    chk("t5_so", so_s, 0);
    chk("t5_rdy", rdy_s, 1);
    chk("t5_done", fdn_s, 0);
    idle(6);
    chk("t5_fd", fd4, 0);

    // accept while Hold is high in IDLE
    clr();
    hold4 = 1'b1;
    if4.Par_IN = 4'hE; if4.In_Valid = 1'b1;
    tick();
    chk("t6_acc", acc4, 1);
    if4.In_Valid = 1'b0;
    idle(2);
    chk("t6_held_ov", ov_s, 0);
    chk("t6_held_nv", nv4, 0);
    hold4 = 1'b0;
    idle(8);
    chk("t6_nv", nv4, 4);
    chk("t6_rx", rx4, 4'hE);
    chk("t6_fd", fd4, 1);

    // WIDTH=8
    clr();
    if8.Par_IN = 8'hC3; if8.In_Valid = 1'b1;
    tick();
    chk("t7_acc", acc8, 1);
    if8.In_Valid = 1'b0;
    idle(12);
    chk("t7_nv", nv8, 8);
    chk("t7_fd", fd8, 1);
    chk("t7_rx", rx8, 8'hC3);
    chk("t7_busy", busy8, 0);
    chk("t7_q", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
